// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose: control bundle between the multicycle MIPS controller and its datapath.
// Latency: none, wires only.
// Backpressure: memory stalls arrive as mem_ready and are resolved inside the controller.
//
// Signals: instruction fields op/funct, ALU zero flag and memory handshake go from the
// datapath to the controller. Enables, mux selects, ALU function and status come back.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic       halted;
    logic [3:0] state_o;

    modport master (
        input  op, funct, zero, mem_ready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op,
               halted, state_o
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op,
               halted, state_o
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Purpose: main control FSM and ALU decoder for the multicycle MIPS datapath.
// Latency: Moore outputs decoded from the state register; pcen also follows zero in the same cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold their state while mem_ready is low.
//
// Ports: clk, reset_n (async active-low) plain; everything else on bus (master modport):
//   inputs op, funct, zero, mem_ready; outputs datapath enables/selects, alucontrol,
//   illegal_op, halted and the 4-bit state for debug.
module mips_multicycle_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    logic       iord_c, memwrite_c, irwrite_c, regdst_c, memtoreg_c, regwrite_c;
    logic       alusrca_c, pcwrite_c, branch_c, illegal_c, halted_c;
    logic [1:0] alusrcb_c, pcsrc_c;
    logic [2:0] alucontrol_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            // Encodings 13-15 are never entered normally; recover to FETCH.
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord_c       = 1'b0;
        memwrite_c   = 1'b0;
        irwrite_c    = 1'b0;
        regdst_c     = 1'b0;
        memtoreg_c   = 1'b0;
        regwrite_c   = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        pcsrc_c      = 2'b00;
        pcwrite_c    = 1'b0;
        branch_c     = 1'b0;
        alucontrol_c = ALU_ADD;
        illegal_c    = 1'b0;
        halted_c     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb_c = 2'b01;
                // Instruction load and PC+4 commit only when the fetch completes.
                irwrite_c = bus.mem_ready;
                pcwrite_c = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alusrcb_c = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_c = 1'b0;
                    default:                                      illegal_c = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
            end
            S_MEMRD:  iord_c = 1'b1;
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
            end
            S_EXEC: begin
                alusrca_c = 1'b1;
                case (bus.funct)
                    6'b100000: alucontrol_c = ALU_ADD;
                    6'b100010: alucontrol_c = ALU_SUB;
                    6'b100100: alucontrol_c = ALU_AND;
                    6'b100101: alucontrol_c = ALU_OR;
                    6'b101010: alucontrol_c = ALU_SLT;
                    default:   alucontrol_c = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
            end
            S_BEQ: begin
                alusrca_c    = 1'b1;
                alucontrol_c = ALU_SUB;
                pcsrc_c      = 2'b01;
                branch_c     = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
            end
            S_ADDIWB: regwrite_c = 1'b1;
            S_JUMP: begin
                pcsrc_c   = 2'b10;
                pcwrite_c = 1'b1;
            end
            S_HALT:   halted_c = 1'b1;
            default: ;
        endcase
    end

    // Reset forces the state to FETCH, so selects already show FETCH values;
    // the enables are gated explicitly so FETCH's mem_ready-driven strobes stay off.
    assign bus.iord       = iord_c;
    assign bus.memwrite   = reset_n & memwrite_c;
    assign bus.irwrite    = reset_n & irwrite_c;
    assign bus.regdst     = regdst_c;
    assign bus.memtoreg   = memtoreg_c;
    assign bus.regwrite   = reset_n & regwrite_c;
    assign bus.alusrca    = alusrca_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.pcsrc      = pcsrc_c;
    assign bus.pcen       = reset_n & (pcwrite_c | (branch_c & bus.zero));
    assign bus.alucontrol = alucontrol_c;
    assign bus.illegal_op = reset_n & illegal_c;
    assign bus.halted     = reset_n & halted_c;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose: scoreboard bench for mips_multicycle_ctrl, one instance per ILLEGAL_TRAP value.
// Latency: expectations are pushed right after each rising edge and checked at the falling edge.
// Backpressure: mem_ready stalls are driven explicitly in the directed vectors.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] alucontrol;
        logic       illegal_op;
        logic       halted;
    } obs_t;

    typedef struct {
        int              dut;
        obs_t            val;
        logic [8*12-1:0] tag;
    } exp_t;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4, MW = 4'd5;
    localparam logic [3:0] EX = 4'd6, WB = 4'd7, BQ = 4'd8, AX = 4'd9, AW = 4'd10, JP = 4'd11, HL = 4'd12;
    localparam logic [5:0] OPR = 6'h00, OPLW = 6'h23, OPSW = 6'h2B, OPBEQ = 6'h04;
    localparam logic [5:0] OPADDI = 6'h08, OPJ = 6'h02, OPBAD = 6'h3F;
    localparam logic [2:0] AADD = 3'b010, ASUB = 3'b110;

    logic clk;
    logic rn0, rn1;
    logic stim_done;
    int   checks, failures;
    exp_t q[$];
    obs_t obs0, obs1;

    mips_multicycle_ctrl_if bus0();
    mips_multicycle_ctrl_if bus1();

    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .reset_n(rn0), .bus(bus0));
    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .reset_n(rn1), .bus(bus1));

    assign obs0 = {bus0.state_o, bus0.iord, bus0.memwrite, bus0.irwrite, bus0.regdst,
                   bus0.memtoreg, bus0.regwrite, bus0.alusrca, bus0.alusrcb, bus0.pcsrc,
                   bus0.pcen, bus0.alucontrol, bus0.illegal_op, bus0.halted};
    assign obs1 = {bus1.state_o, bus1.iord, bus1.memwrite, bus1.irwrite, bus1.regdst,
                   bus1.memtoreg, bus1.regwrite, bus1.alusrca, bus1.alusrcb, bus1.pcsrc,
                   bus1.pcen, bus1.alucontrol, bus1.illegal_op, bus1.halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-state control table taken from the state descriptions; alucontrol and
    // the illegal flag are supplied by each vector.
    function automatic obs_t expect_of(input logic [3:0] st, input logic [2:0] alu,
                                       input logic z, input logic mr, input logic rn,
                                       input logic ill);
        obs_t e;
        e = '0;
        e.state      = st;
        e.alucontrol = alu;
        if (!rn) begin
            e.alusrcb = 2'b01;
            return e;
        end
        case (st)
            F:  begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
            D:  begin e.alusrcb = 2'b11; e.illegal_op = ill; end
            MA: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            MR: e.iord = 1'b1;
            MB: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            MW: begin e.iord = 1'b1; e.memwrite = 1'b1; end
            EX: e.alusrca = 1'b1;
            WB: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            BQ: begin e.alusrca = 1'b1; e.pcsrc = 2'b01; e.pcen = z; end
            AX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            AW: e.regwrite = 1'b1;
            JP: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            HL: e.halted = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic drive(input logic r0, input logic r1, input logic [5:0] o,
                         input logic [5:0] f, input logic z, input logic m);
        @(posedge clk);
        #1;
        rn0 = r0;
        rn1 = r1;
        bus0.op = o;  bus0.funct = f;  bus0.zero = z;  bus0.mem_ready = m;
        bus1.op = o;  bus1.funct = f;  bus1.zero = z;  bus1.mem_ready = m;
    endtask

    task automatic want(input int d, input logic [3:0] st, input logic [2:0] alu,
                        input logic ill, input logic [8*12-1:0] tag);
        exp_t e;
        e.dut = d;
        e.val = expect_of(st, alu, bus0.zero, bus0.mem_ready, (d == 1) ? rn1 : rn0, ill);
        e.tag = tag;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            while (q.size() != 0) begin
                e = q.pop_front();
                a = (e.dut == 1) ? obs1 : obs0;
                checks++;
                if (a !== e.val) begin
                    failures++;
                    $display("FAIL %0s dut%0d got=%06h want=%06h", e.tag, e.dut, a, e.val);
                end
            end
            if (stim_done) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] fn  [5];
        logic [2:0] alu [5];
        fn[0] = 6'h22; alu[0] = 3'b110;
        fn[1] = 6'h24; alu[1] = 3'b000;
        fn[2] = 6'h25; alu[2] = 3'b001;
        fn[3] = 6'h2A; alu[3] = 3'b111;
        fn[4] = 6'h3F; alu[4] = 3'b010;
        checks = 0; failures = 0; stim_done = 1'b0;
        rn0 = 1'b0; rn1 = 1'b0;
        bus0.op = OPR; bus0.funct = 6'h20; bus0.zero = 1'b0; bus0.mem_ready = 1'b1;
        bus1.op = OPR; bus1.funct = 6'h20; bus1.zero = 1'b0; bus1.mem_ready = 1'b1;

        drive(0, 0, OPR, 6'h20, 0, 1); want(0, F, AADD, 0, "rst0"); want(1, F, AADD, 0, "rst1");

        drive(1, 0, OPR, 6'h20, 0, 1); want(0, F,  AADD, 0, "add_f");
        drive(1, 0, OPR, 6'h20, 1, 0); want(0, D,  AADD, 0, "add_d");
        drive(1, 0, OPR, 6'h20, 0, 1); want(0, EX, AADD, 0, "add_ex");
        drive(1, 0, OPR, 6'h20, 1, 1); want(0, WB, AADD, 0, "add_wb");

        drive(1, 0, OPLW, 6'h00, 0, 0); want(0, F,  AADD, 0, "lw_fstall");
        drive(1, 0, OPLW, 6'h00, 0, 1); want(0, F,  AADD, 0, "lw_f");
        drive(1, 0, OPLW, 6'h00, 0, 0); want(0, D,  AADD, 0, "lw_d");
        drive(1, 0, OPLW, 6'h00, 0, 0); want(0, MA, AADD, 0, "lw_ma");
        drive(1, 0, OPLW, 6'h00, 0, 0); want(0, MR, AADD, 0, "lw_mr0");
        drive(1, 0, OPLW, 6'h00, 0, 0); want(0, MR, AADD, 0, "lw_mr1");
        drive(1, 0, OPLW, 6'h00, 0, 1); want(0, MR, AADD, 0, "lw_mr2");
        drive(1, 0, OPLW, 6'h00, 0, 0); want(0, MB, AADD, 0, "lw_wb");

        drive(1, 0, OPSW, 6'h00, 0, 1); want(0, F,  AADD, 0, "sw_f");
        drive(1, 0, OPSW, 6'h00, 0, 1); want(0, D,  AADD, 0, "sw_d");
        drive(1, 0, OPSW, 6'h00, 0, 1); want(0, MA, AADD, 0, "sw_ma");
        drive(1, 0, OPSW, 6'h00, 0, 1); want(0, MW, AADD, 0, "sw_mw");

        drive(1, 0, OPBEQ, 6'h00, 0, 1); want(0, F,  AADD, 0, "beq1_f");
        drive(1, 0, OPBEQ, 6'h00, 0, 1); want(0, D,  AADD, 0, "beq1_d");
        drive(1, 0, OPBEQ, 6'h00, 1, 1); want(0, BQ, ASUB, 0, "beq1_bq");
        drive(1, 0, OPBEQ, 6'h00, 1, 1); want(0, F,  AADD, 0, "beq0_f");
        drive(1, 0, OPBEQ, 6'h00, 1, 1); want(0, D,  AADD, 0, "beq0_d");
        drive(1, 0, OPBEQ, 6'h00, 0, 1); want(0, BQ, ASUB, 0, "beq0_bq");

        for (int i = 0; i < 5; i++) begin
            drive(1, 0, OPR, fn[i], 0, 1); want(0, F,  AADD,   0, "r_f");
            drive(1, 0, OPR, fn[i], 0, 1); want(0, D,  AADD,   0, "r_d");
            drive(1, 0, OPR, fn[i], 0, 1); want(0, EX, alu[i], 0, "r_ex");
            drive(1, 0, OPR, fn[i], 0, 1); want(0, WB, AADD,   0, "r_wb");
        end

        drive(1, 0, OPADDI, 6'h00, 0, 1); want(0, F,  AADD, 0, "addi_f");
        drive(1, 0, OPADDI, 6'h00, 0, 1); want(0, D,  AADD, 0, "addi_d");
        drive(1, 0, OPADDI, 6'h00, 0, 1); want(0, AX, AADD, 0, "addi_ex");
        drive(1, 0, OPADDI, 6'h00, 0, 1); want(0, AW, AADD, 0, "addi_wb");
        drive(1, 0, OPJ,    6'h00, 0, 1); want(0, F,  AADD, 0, "j_f");
        drive(1, 0, OPJ,    6'h00, 0, 1); want(0, D,  AADD, 0, "j_d");
        drive(1, 0, OPJ,    6'h00, 0, 1); want(0, JP, AADD, 0, "j_jp");

        drive(1, 0, OPR, 6'h20, 1, 1); want(0, F,  AADD, 0, "rx_f");
        drive(1, 0, OPR, 6'h20, 1, 1); want(0, D,  AADD, 0, "rx_d");
        drive(0, 0, OPR, 6'h20, 1, 1); want(0, F,  AADD, 0, "rx_abort");
        #1;
        checks++;
        if (bus0.state_o !== F) begin
            failures++;
            $display("FAIL rx_abort_state got=%0d want=%0d", bus0.state_o, F);
        end
        checks++;
        if (bus0.regwrite !== 1'b0) begin
            failures++;
            $display("FAIL rx_abort_regwrite got=%0b want=0", bus0.regwrite);
        end
        checks++;
        if (bus0.pcen !== 1'b0) begin
            failures++;
            $display("FAIL rx_abort_pcen got=%0b want=0", bus0.pcen);
        end
        drive(0, 0, OPR, 6'h20, 1, 1); want(0, F,  AADD, 0, "rx_hold");
        drive(1, 0, OPR, 6'h20, 0, 1); want(0, F,  AADD, 0, "rx_f2");
        drive(1, 0, OPR, 6'h20, 0, 1); want(0, D,  AADD, 0, "rx_d2");
        drive(1, 0, OPR, 6'h20, 0, 1); want(0, EX, AADD, 0, "rx_ex2");
        drive(1, 0, OPR, 6'h20, 0, 1); want(0, WB, AADD, 0, "rx_wb2");

        drive(1, 1, OPBAD, 6'h00, 0, 1); want(0, F, AADD, 0, "ill_f0"); want(1, F, AADD, 0, "ill_f1");
        drive(1, 1, OPBAD, 6'h00, 0, 0); want(0, D, AADD, 1, "ill_d0"); want(1, D, AADD, 1, "ill_d1");
        #1;
        checks++;
        if (bus0.illegal_op !== 1'b1) begin
            failures++;
            $display("FAIL ill_pulse got=%0b want=1", bus0.illegal_op);
        end
        drive(1, 1, OPBAD, 6'h00, 0, 0); want(0, F, AADD, 0, "ill_back"); want(1, HL, AADD, 0, "ill_halt");
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, OPLW, 6'h20, i[0], i[1]); want(1, HL, AADD, 0, "halt_hold");
        end
        #1;
        checks++;
        if (bus1.halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_level got=%0b want=1", bus1.halted);
        end
        drive(1, 0, OPLW, 6'h20, 0, 1); want(1, F, AADD, 0, "halt_rst");

        stim_done = 1'b1;
    end

endmodule
